// File: rtl/calc_sequencer.sv
// Sequencer for the calculator add/subtract path: time-shares one external
// 8-bit adder over a raw pass and an optional two's-complement correction pass.
module calc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       ready,
  input  logic       op_sub,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] adder_x,
  output logic [7:0] adder_y,
  output logic       adder_sub,
  input  logic [7:0] adder_s,
  input  logic       adder_cout,
  output logic       result_valid,
  input  logic       result_ack,
  output logic       sign,
  output logic [8:0] magnitude,
  output logic       busy
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a_r, b_r, sum_r;
  logic                op_sub_r;
  logic                need_fix;

  // A borrow out of the raw subtract means A<B and the difference must be negated.
  assign need_fix = op_sub_r && !adder_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ready        = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    adder_x      = '0;
    adder_y      = '0;
    adder_sub    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) state_nxt = PASS1;
      end
      PASS1: begin
        adder_x   = a_r;
        adder_y   = b_r;
        adder_sub = op_sub_r;
        state_nxt = need_fix ? PASS2 : DONE;
      end
      PASS2: begin
        adder_x   = '0;
        adder_y   = sum_r;
        adder_sub = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and raw-difference holding register; no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_r      <= A;
      b_r      <= B;
      op_sub_r <= op_sub;
    end
    if (state == PASS1) sum_r <= adder_s;
  end

  // Result register holds its value through IDLE until the next result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign      <= 1'b0;
      magnitude <= '0;
    end else if (state == PASS1 && !need_fix) begin
      sign      <= 1'b0;
      magnitude <= op_sub_r ? {1'b0, adder_s} : {adder_cout, adder_s};
    end else if (state == PASS2) begin
      sign      <= 1'b1;
      magnitude <= {1'b0, adder_s};
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: external adder model, directed cases, then random
// operations checked against a plain-arithmetic reference.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready;
  logic       op_sub = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [7:0] adder_x, adder_y, adder_s;
  logic       adder_sub, adder_cout;
  logic       result_valid;
  logic       result_ack = 1'b0;
  logic       sign;
  logic [8:0] magnitude;
  logic       busy;
  logic [8:0] add_res;

  int n_chk = 0;
  int n_pass = 0;

  calc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .op_sub(op_sub),
    .A(A), .B(B), .adder_x(adder_x), .adder_y(adder_y), .adder_sub(adder_sub),
    .adder_s(adder_s), .adder_cout(adder_cout), .result_valid(result_valid),
    .result_ack(result_ack), .sign(sign), .magnitude(magnitude), .busy(busy)
  );

  always #5 clk = ~clk;

  // External shared adder: X + Y, or X + ~Y + 1 when subtracting.
  always_comb begin
    if (adder_sub) add_res = {1'b0, adder_x} + {1'b0, ~adder_y} + 9'd1;
    else           add_res = {1'b0, adder_x} + {1'b0, adder_y};
  end
  assign adder_s    = add_res[7:0];
  assign adder_cout = add_res[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_result(input int a, input int b, input bit sub,
                                     output bit s, output int m);
    int r;
    r = sub ? a - b : a + b;
    s = (r < 0);
    m = (r < 0) ? -r : r;
  endfunction

  // Present one request and follow it to DONE, checking adder traffic and latency.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit sub);
    bit exp_s;
    int exp_m, lat, waited;
    waited = 0;
    while (!ready && waited < 10) begin
      tick();
      waited++;
    end
    chk("ready_before_start", ready, 1);
    ref_result(a, b, sub, exp_s, exp_m);
    lat = (sub && a < b) ? 3 : 2;
    A = a; B = b; op_sub = sub; start = 1'b1;
    tick();
    start = 1'b0;
    chk("p1_busy", {ready, busy, result_valid}, 3'b010);
    chk("p1_adder", {adder_x, adder_y, adder_sub}, {a, b, sub});
    tick();
    if (lat == 3) begin
      chk("p2_valid", result_valid, 0);
      chk("p2_adder", {adder_x, adder_y, adder_sub}, {8'h00, 8'((int'(a) + 256 - int'(b)) % 256), 1'b1});
      tick();
    end
    chk("done_valid", result_valid, 1);
    chk("done_adder_idle", {adder_x, adder_y, adder_sub}, 17'h0);
    chk("result", {sign, magnitude}, {exp_s, 9'(exp_m)});
  endtask

  task automatic ack_now();
    logic [9:0] held;
    held = {sign, magnitude};
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("after_ack", {ready, busy, result_valid}, 3'b100);
    chk("result_held_idle", {sign, magnitude}, held);
  endtask

  initial begin
    logic [9:0] held;
    #12;
    chk("reset_ctrl", {ready, busy, result_valid}, 3'b100);
    chk("reset_result", {sign, magnitude}, 10'h0);
    chk("reset_adder", {adder_x, adder_y, adder_sub}, 17'h0);
    rst_n = 1'b1;
    tick();

    issue(8'h12, 8'h34, 1'b0); ack_now();
    issue(8'hFF, 8'hFF, 1'b0); ack_now();
    issue(8'h50, 8'h20, 1'b1); ack_now();
    issue(8'h7F, 8'h7F, 1'b1); ack_now();
    issue(8'h05, 8'h0C, 1'b1); ack_now();
    issue(8'h00, 8'hFF, 1'b1); ack_now();

    // Hold the result while start pulses are offered and must be ignored.
    issue(8'h0A, 8'h03, 1'b1);
    held = {sign, magnitude};
    for (int i = 0; i < 5; i++) begin
      start = i[0]; A = 8'hAA; B = 8'h55; op_sub = 1'b0;
      tick();
      chk("hold_valid", {result_valid, ready}, 2'b10);
      chk("hold_result", {sign, magnitude}, held);
    end
    start = 1'b1; result_ack = 1'b1;
    tick();
    start = 1'b0; result_ack = 1'b0;
    chk("ack_with_start", {ready, busy, result_valid}, 3'b100);
    tick();
    chk("start_not_taken", {ready, busy}, 2'b10);

    // Asynchronous reset while the correction pass is in flight.
    A = 8'h05; B = 8'h0C; op_sub = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("in_pass2", adder_sub, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {ready, busy, result_valid}, 3'b100);
    chk("abort_result", {sign, magnitude}, 10'h0);
    chk("abort_adder", {adder_x, adder_y, adder_sub}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(8'h01, 8'h01, 1'b0); ack_now();

    for (int n = 0; n < 40; n++) begin
      int dly;
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      dly = $urandom_range(0, 2);
      held = {sign, magnitude};
      for (int d = 0; d < dly; d++) begin
        tick();
        chk("rand_hold", {result_valid, sign, magnitude}, {1'b1, held});
      end
      ack_now();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
